multicycle_seq: RTL and testbench

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

---
 rtl/multicycle_seq.sv | 244 ++++++++++++++++++++++++
 tb/tb_multicycle_seq.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
// ----------------------------------------------------------------------------
// multicycle_seq : multicycle CPU control sequencer with timed memory handshake
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module multicycle_seq #(
  parameter int TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] op_code,
  input  logic       mem_ready,
  input  logic       cond_true,
  output logic       pc_write,
  output logic [1:0] pc_src,
  output logic       ir_write,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       r15_write,
  output logic       branch,
  output logic [2:0] state,
  output logic       ill_op,
  output logic       bus_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] c_timeout = 4'(TIMEOUT);

  localparam logic [1:0] c_pc_plus2  = 2'b00;
  localparam logic [1:0] c_pc_branch = 2'b01;
  localparam logic [1:0] c_pc_jump   = 2'b10;

  localparam logic [1:0] c_alu_add = 2'b00;
  localparam logic [1:0] c_alu_sub = 2'b01;
  localparam logic [1:0] c_alu_imm = 2'b10;
  localparam logic [1:0] c_alu_rty = 2'b11;

  // Opcode classes
  function automatic logic is_rtype(input logic [3:0] op);
    return op == 4'b1111;
  endfunction

  function automatic logic is_imm(input logic [3:0] op);
    return (op == 4'b1000) || (op == 4'b1001);
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == 4'b1010) || (op == 4'b1100);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == 4'b1011) || (op == 4'b1101);
  endfunction

  function automatic logic is_branch(input logic [3:0] op);
    return (op == 4'b0100) || (op == 4'b0101) || (op == 4'b0110);
  endfunction

  state_e     state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [3:0] wait_q, wait_d;
  logic       ill_op_q, ill_op_d;
  logic       bus_err_q, bus_err_d;

  // Ungated strobes, masked by rst_n at the output
  logic       pc_write_c;
  logic [1:0] pc_src_c;
  logic       ir_write_c;
  logic       alu_src_c;
  logic [1:0] alu_op_c;
  logic       mem_read_c;
  logic       mem_write_c;
  logic       mem_to_reg_c;
  logic       reg_write_c;
  logic       r15_write_c;
  logic       branch_c;
  logic       timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      op_q      <= 4'd0;
      wait_q    <= 4'd0;
      ill_op_q  <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      ill_op_q  <= ill_op_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    ill_op_d     = ill_op_q;
    bus_err_d    = bus_err_q;
    pc_write_c   = 1'b0;
    pc_src_c     = c_pc_plus2;
    ir_write_c   = 1'b0;
    alu_src_c    = 1'b0;
    alu_op_c     = c_alu_add;
    mem_read_c   = 1'b0;
    mem_write_c  = 1'b0;
    mem_to_reg_c = 1'b0;
    reg_write_c  = 1'b0;
    r15_write_c  = 1'b0;
    branch_c     = 1'b0;
    timed_out    = !mem_ready && (wait_q == c_timeout);

    case (state_q)
      S_FETCH: begin
        mem_read_c = 1'b1;
        if (mem_ready) begin
          ir_write_c = 1'b1;
          pc_write_c = 1'b1;
          pc_src_c   = c_pc_plus2;
          state_d    = S_DECODE;
        end else if (timed_out) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end
      end

      // The opcode is still on op_code here; op_q captures it at this edge
      S_DECODE: begin
        op_d = op_code;
        if (is_rtype(op_code) || is_imm(op_code) || is_load(op_code) ||
            is_store(op_code) || is_branch(op_code)) begin
          state_d = S_EXEC;
        end else if (op_code == 4'b0001) begin
          pc_write_c = 1'b1;
          pc_src_c   = c_pc_jump;
          state_d    = S_FETCH;
        end else if (op_code == 4'b0000) begin
          state_d = S_HALT;
        end else begin
          ill_op_d = 1'b1;
          state_d  = S_FETCH;
        end
      end

      S_EXEC: begin
        state_d = S_FETCH;
        if (is_rtype(op_q)) begin
          alu_src_c = 1'b0;
          alu_op_c  = c_alu_rty;
          state_d   = S_WB;
        end else if (is_imm(op_q)) begin
          alu_src_c = 1'b1;
          alu_op_c  = c_alu_imm;
          state_d   = S_WB;
        end else if (is_load(op_q) || is_store(op_q)) begin
          alu_src_c = 1'b1;
          alu_op_c  = c_alu_add;
          state_d   = S_MEM;
        end else if (is_branch(op_q)) begin
          alu_src_c = 1'b0;
          alu_op_c  = c_alu_sub;
          branch_c  = 1'b1;
          if (cond_true) begin
            pc_write_c = 1'b1;
            pc_src_c   = c_pc_branch;
          end
        end
      end

      S_MEM: begin
        mem_read_c  = is_load(op_q);
        mem_write_c = is_store(op_q);
        if (!is_load(op_q) && !is_store(op_q)) begin
          state_d = S_FETCH;
        end else if (mem_ready) begin
          state_d = is_load(op_q) ? S_WB : S_FETCH;
        end else if (timed_out) begin
          bus_err_d = 1'b1;
          state_d   = S_HALT;
        end
      end

      S_WB: begin
        reg_write_c  = 1'b1;
        mem_to_reg_c = is_load(op_q);
        r15_write_c  = is_rtype(op_q);
        state_d      = S_FETCH;
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Wait counter only runs while a memory access is outstanding
  always_comb begin
    wait_d = 4'd0;
    if ((state_d == state_q) && !mem_ready &&
        ((state_q == S_FETCH) || (state_q == S_MEM))) begin
      wait_d = wait_q + 4'd1;
    end
  end

  // rst_n masks strobes directly so a reset mid-access drops requests at once
  always_comb begin
    pc_write   = rst_n & pc_write_c;
    pc_src     = rst_n ? pc_src_c : 2'b00;
    ir_write   = rst_n & ir_write_c;
    alu_src    = rst_n & alu_src_c;
    alu_op     = rst_n ? alu_op_c : 2'b00;
    mem_read   = rst_n & mem_read_c;
    mem_write  = rst_n & mem_write_c;
    mem_to_reg = rst_n & mem_to_reg_c;
    reg_write  = rst_n & reg_write_c;
    r15_write  = rst_n & r15_write_c;
    branch     = rst_n & branch_c;
  end

  assign state   = state_q;
  assign ill_op  = ill_op_q;
  assign bus_err = bus_err_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_seq.sv
// ----------------------------------------------------------------------------
// tb_multicycle_seq : directed self-checking bench for multicycle_seq
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_seq;

  logic       clk;
  logic       rst_n;
  logic [3:0] op_code;
  logic       mem_ready;
  logic       cond_true;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       alu_src;
  logic [1:0] alu_op;
  logic       mem_read;
  logic       mem_write;
  logic       mem_to_reg;
  logic       reg_write;
  logic       r15_write;
  logic       branch;
  logic [2:0] state;
  logic       ill_op;
  logic       bus_err;

  int checks   = 0;
  int failures = 0;

  multicycle_seq #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op_code    (op_code),
    .mem_ready  (mem_ready),
    .cond_true  (cond_true),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .ir_write   (ir_write),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_to_reg (mem_to_reg),
    .reg_write  (reg_write),
    .r15_write  (r15_write),
    .branch     (branch),
    .state      (state),
    .ill_op     (ill_op),
    .bus_err    (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [12:0] strobes;
  assign strobes = {pc_write, pc_src, ir_write, alu_src, alu_op, mem_read,
                    mem_write, mem_to_reg, reg_write, r15_write, branch};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    op_code   = 4'd0;
    mem_ready = 1'b0;
    cond_true = 1'b0;
    #2;
    chk("rst_state", state, 0);
    chk("rst_strobes", strobes, 0);
    chk("rst_ill", ill_op, 0);
    chk("rst_bus", bus_err, 0);

    // Load, zero wait
    cyc(); rst_n = 1'b1; mem_ready = 1'b1; op_code = 4'b1010; #1;
    chk("ld_fetch_state", state, 0);
    chk("ld_fetch_rd", mem_read, 1);
    chk("ld_fetch_ir", ir_write, 1);
    chk("ld_fetch_pcw", pc_write, 1);
    chk("ld_fetch_pcsrc", pc_src, 0);
    cyc(); #1;
    chk("ld_decode_state", state, 1);
    chk("ld_decode_rd", mem_read, 0);
    cyc(); #1;
    chk("ld_exec_state", state, 2);
    chk("ld_exec_alusrc", alu_src, 1);
    chk("ld_exec_aluop", alu_op, 0);
    cyc(); #1;
    chk("ld_mem_state", state, 3);
    chk("ld_mem_rd", mem_read, 1);
    cyc(); #1;
    chk("ld_wb_state", state, 4);
    chk("ld_wb_regw", reg_write, 1);
    chk("ld_wb_m2r", mem_to_reg, 1);
    chk("ld_wb_r15", r15_write, 0);

    // Branch taken
    cyc(); op_code = 4'b0101; cond_true = 1'b1; #1;
    chk("ld_done_fetch", state, 0);
    cyc(); #1;
    chk("bt_decode", state, 1);
    cyc(); #1;
    chk("bt_exec_state", state, 2);
    chk("bt_pcw", pc_write, 1);
    chk("bt_pcsrc", pc_src, 1);
    chk("bt_branch", branch, 1);
    chk("bt_aluop", alu_op, 1);

    // Branch not taken
    cyc(); cond_true = 1'b0; #1;
    chk("bt_back_fetch", state, 0);
    cyc(); cyc(); #1;
    chk("bn_exec_state", state, 2);
    chk("bn_pcw", pc_write, 0);
    chk("bn_branch", branch, 1);

    // Store with three wait cycles
    cyc(); op_code = 4'b1101; #1;
    chk("st_fetch", state, 0);
    cyc(); #1;
    chk("st_decode", state, 1);
    cyc(); mem_ready = 1'b0; #1;
    chk("st_exec", state, 2);
    for (int i = 0; i < 3; i++) begin
      cyc(); #1;
      chk("st_wait_state", state, 3);
      chk("st_wait_wr", mem_write, 1);
      chk("st_wait_regw", reg_write, 0);
    end
    cyc(); mem_ready = 1'b1; #1;
    chk("st_last_wr", mem_write, 1);
    chk("st_last_rd", mem_read, 0);
    chk("st_last_regw", reg_write, 0);

    // Illegal opcode
    cyc(); op_code = 4'b0111; #1;
    chk("st_done_fetch", state, 0);
    cyc(); #1;
    chk("il_decode", state, 1);
    chk("il_not_yet", ill_op, 0);
    cyc(); op_code = 4'b1000; mem_ready = 1'b0; #1;
    chk("il_fetch", state, 0);
    chk("il_flag", ill_op, 1);

    // mem_ready on the cycle the wait counter equals TIMEOUT: no error
    for (int i = 0; i < 14; i++) begin
      cyc(); #1;
    end
    cyc(); mem_ready = 1'b1; #1;
    chk("tw_state", state, 0);
    chk("tw_ir", ir_write, 1);
    chk("tw_bus", bus_err, 0);
    cyc(); #1;
    chk("tw_decode", state, 1);
    chk("tw_bus2", bus_err, 0);
    cyc(); #1;
    chk("imm_exec_alusrc", alu_src, 1);
    chk("imm_exec_aluop", alu_op, 2);
    cyc(); #1;
    chk("imm_wb_state", state, 4);
    chk("imm_wb_regw", reg_write, 1);
    chk("imm_wb_m2r", mem_to_reg, 0);
    chk("imm_wb_r15", r15_write, 0);

    // Reset pulsed during a load's MEM wait
    cyc(); op_code = 4'b1100; #1;
    chk("rm_fetch", state, 0);
    cyc(); cyc(); mem_ready = 1'b0; #1;
    chk("rm_exec", state, 2);
    cyc(); #1;
    chk("rm_mem_state", state, 3);
    chk("rm_mem_rd", mem_read, 1);
    #2; rst_n = 1'b0; #1;
    chk("rm_rd_dropped", mem_read, 0);
    chk("rm_state", state, 0);
    chk("rm_ill_clear", ill_op, 0);

    // R-type after reset
    cyc(); rst_n = 1'b1; mem_ready = 1'b1; op_code = 4'b1111; #1;
    chk("rt_fetch_rd", mem_read, 1);
    cyc(); cyc(); #1;
    chk("rt_exec_state", state, 2);
    chk("rt_exec_alusrc", alu_src, 0);
    chk("rt_exec_aluop", alu_op, 3);
    cyc(); #1;
    chk("rt_wb_state", state, 4);
    chk("rt_wb_regw", reg_write, 1);
    chk("rt_wb_r15", r15_write, 1);
    chk("rt_wb_m2r", mem_to_reg, 0);

    // Jump
    cyc(); op_code = 4'b0001; #1;
    chk("jp_fetch", state, 0);
    cyc(); mem_ready = 1'b0; #1;
    chk("jp_decode", state, 1);
    chk("jp_pcw", pc_write, 1);
    chk("jp_pcsrc", pc_src, 2);

    // Timeout with mem_ready stuck low in FETCH
    cyc(); op_code = 4'b0000; #1;
    chk("to_fetch", state, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(); #1;
    end
    chk("to_last_state", state, 0);
    chk("to_last_rd", mem_read, 1);
    chk("to_last_bus", bus_err, 0);
    cyc(); #1;
    chk("to_halt_state", state, 5);
    chk("to_bus", bus_err, 1);
    chk("to_rd_dropped", mem_read, 0);

    // Halt opcode
    cyc(); rst_n = 1'b0; #1;
    chk("hl_rst_bus", bus_err, 0);
    chk("hl_rst_state", state, 0);
    cyc(); rst_n = 1'b1; mem_ready = 1'b1; op_code = 4'b0000; #1;
    chk("hl_fetch", state, 0);
    cyc(); #1;
    chk("hl_decode", state, 1);
    for (int i = 0; i < 22; i++) begin
      cyc(); #1;
      chk("hl_state", state, 5);
      chk("hl_strobes", strobes, 0);
    end
    chk("hl_ill", ill_op, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
